// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift-register arbiter.
// Optional feature macro: SHIFT_ARB_PARITY_EN (adds a trailing even-parity bit per transfer).
package shift_arb_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // One-hot grant vector for a two-requester arbiter.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in / parallel-out shift register. Bits enter at the MSB and move
// toward the LSB, so the first bit received ends up in q[0].
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr_sync,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Synchronous clear wins over shift so a fresh grant always starts from zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (clr_sync) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one SIPO shifter between two serial
// requesters; the assembled word is offered on a valid/ready port tagged
// with its source.
// Optional feature macro: SHIFT_ARB_PARITY_EN (one extra granted cycle samples
// an even-parity bit; mismatch reported on out_perr). Undefined: out_perr = 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transfer; arbitrate pending requests
// ST_SHIFT  | grant held, one data bit shifted per cycle
// ST_PARITY | grant held one extra cycle to sample the parity bit
// ST_HOLD   | word presented on out_*, waiting for out_ready
module shift_arb_ctrl
    import shift_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [1:0]       req,
    input  logic [1:0]       sdata,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_perr
);

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               pick;
    logic               start;
    logic               last_bit;
    logic               shift_en;
    logic [WIDTH-1:0]   shreg;
`ifdef SHIFT_ARB_PARITY_EN
    logic               perr_q, perr_d;
`endif

    // A lone requester wins outright; the rr pointer only breaks ties.
    assign pick     = (req == 2'b11) ? rr_q : req[1];
    assign start    = (state_q == ST_IDLE) && (req != 2'b00);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign shift_en = (state_q == ST_SHIFT);

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (clk),
        .clr_n    (clr_n),
        .clr_sync (start),
        .en       (shift_en),
        .din      (sdata[sel_q]),
        .q        (shreg)
    );

    // State and registered-output flops.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHIFT_ARB_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef SHIFT_ARB_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SHIFT_ARB_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_HOLD;
`endif
                end
            end
`ifdef SHIFT_ARB_PARITY_EN
            ST_PARITY: state_d = ST_HOLD;
`endif
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath bookkeeping.
    always_comb begin
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        busy_d  = (state_d != ST_IDLE);
`ifdef SHIFT_ARB_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d = pick;
                    gnt_d = onehot2(pick);
                    cnt_d = '0;
`ifdef SHIFT_ARB_PARITY_EN
                    perr_d = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
`ifndef SHIFT_ARB_PARITY_EN
                    gnt_d   = 2'b00;
                    valid_d = 1'b1;
`endif
                end
            end
`ifdef SHIFT_ARB_PARITY_EN
            ST_PARITY: begin
                gnt_d   = 2'b00;
                valid_d = 1'b1;
                perr_d  = (^shreg) ^ sdata[sel_q];
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    rr_d    = ~sel_q;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = shreg;
    assign out_src   = sel_q;
`ifdef SHIFT_ARB_PARITY_EN
    assign out_perr  = perr_q;
`else
    assign out_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Self-checking bench for shift_arb_ctrl: reset checks, a directed transfer
// table, a reset-during-shift sequence and a randomized run against a
// transaction-level model. Honours SHIFT_ARB_PARITY_EN when defined.
module tb_shift_arb_ctrl;

    localparam int WIDTH = 8;
`ifdef SHIFT_ARB_PARITY_EN
    localparam int LEN = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int LEN = WIDTH;
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr_n;
    logic [1:0]       req_r;
    logic [1:0]       sdata_r;
    logic             ready_r;
    logic [1:0]       gnt;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_perr;

    int n_chk  = 0;
    int n_fail = 0;

    shift_arb_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req_r),
        .sdata     (sdata_r),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (ready_r),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_perr  (out_perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] w0;
        logic [7:0] w1;
        logic       p0;
        logic       p1;
        int         stall;
        bit         drop;
        logic       src;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    function automatic logic eperr(input logic [7:0] d, input logic p);
        return PAR ? ((^d) ^ p) : 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer from IDLE through handshake, described by a table row.
    task automatic run_vec(input vec_t v, input int idx);
        logic       src;
        logic [7:0] w;
        logic       p;
        src = v.src;
        w   = src ? v.w1 : v.w0;
        p   = src ? v.p1 : v.p0;
        req_r   = v.req;
        ready_r = (v.stall == 0);
        step();
        chk($sformatf("v%0d grant", idx), gnt, oh(v.src));
        chk($sformatf("v%0d busy", idx), busy, 1);
        for (int k = 0; k < LEN; k++) begin
            sdata_r = 2'($urandom);
            sdata_r[src] = (k < WIDTH) ? w[k] : p;
            if (v.drop && k == 4) req_r[src] = 1'b0;
            step();
            if (k < LEN - 1) begin
                chk($sformatf("v%0d gnt_shift", idx), gnt, oh(v.src));
                chk($sformatf("v%0d valid_shift", idx), out_valid, 0);
            end else begin
                chk($sformatf("v%0d gnt_end", idx), gnt, 0);
                chk($sformatf("v%0d valid", idx), out_valid, 1);
                chk($sformatf("v%0d data", idx), out_data, v.data);
                chk($sformatf("v%0d src", idx), out_src, v.src);
                chk($sformatf("v%0d perr", idx), out_perr, eperr(v.data, p));
            end
        end
        for (int s = 0; s < v.stall; s++) begin
            req_r   = 2'($urandom);
            ready_r = 1'b0;
            step();
            chk($sformatf("v%0d hold_valid", idx), out_valid, 1);
            chk($sformatf("v%0d hold_data", idx), out_data, v.data);
            chk($sformatf("v%0d hold_src", idx), out_src, v.src);
            chk($sformatf("v%0d hold_gnt", idx), gnt, 0);
        end
        ready_r = 1'b1;
        req_r   = 2'($urandom);
        step();
        chk($sformatf("v%0d ack_valid", idx), out_valid, 0);
        chk($sformatf("v%0d ack_gnt", idx), gnt, 0);
        chk($sformatf("v%0d ack_busy", idx), busy, 0);
    endtask

    bit         pend[2];
    logic [7:0] wd[2];
    logic       pb[2];
    int         mph;
    int         cnt;
    logic       w_m;
    logic       rr_m;
    logic [7:0] cw;
    logic       cp;
    logic [1:0] req_e;
    logic       rdy_e;

    initial begin
        tbl[0] = '{2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h3C};
        tbl[1] = '{2'b11, 8'h3C, 8'hC3, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'hC3};
        tbl[2] = '{2'b11, 8'h5A, 8'hC3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h5A};
        tbl[3] = '{2'b10, 8'h00, 8'hA5, 1'b0, 1'b0, 5, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{2'b10, 8'h00, 8'h96, 1'b0, 1'b1, 0, 1'b1, 1'b1, 8'h96};
        tbl[5] = '{2'b11, 8'hE7, 8'h0F, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'hE7};
        tbl[6] = '{2'b01, 8'hA5, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'hA5};
        tbl[7] = '{2'b11, 8'h11, 8'h0F, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'h0F};

        clr_n   = 1'b0;
        req_r   = 2'b00;
        sdata_r = 2'b00;
        ready_r = 1'b0;
        #3;
        chk("rst gnt", gnt, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", out_valid, 0);
        chk("rst data", out_data, 0);
        chk("rst src", out_src, 0);
        chk("rst perr", out_perr, 0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        step();
        chk("idle gnt", gnt, 0);
        chk("idle busy", busy, 0);

        // Reset during the shift phase drops the partial word.
        req_r = 2'b10;
        step();
        chk("mid grant", gnt, 2'b10);
        for (int k = 0; k < 3; k++) begin
            sdata_r = 2'b11;
            step();
        end
        chk("mid src", out_src, 1);
        #3;
        clr_n = 1'b0;
        #1;
        chk("mid_rst gnt", gnt, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst valid", out_valid, 0);
        chk("mid_rst data", out_data, 0);
        chk("mid_rst src", out_src, 0);
        chk("mid_rst perr", out_perr, 0);
        @(posedge clk);
        #1;
        clr_n   = 1'b1;
        req_r   = 2'b00;
        ready_r = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sdata_r = 2'($urandom);
            step();
            chk("post_rst valid", out_valid, 0);
            chk("post_rst gnt", gnt, 0);
            chk("post_rst busy", busy, 0);
        end

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Randomized traffic against a transaction-level model.
        req_r = 2'b00;
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        mph  = 0;
        cnt  = 0;
        w_m  = 1'b0;
        rr_m = 1'b0;
        cw   = '0;
        cp   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    wd[i]   = 8'($urandom);
                    pb[i]   = 1'($urandom);
                end
            end
            for (int i = 0; i < 2; i++)
                req_r[i] = pend[i] | ((mph != 0) && (w_m == i[0]) && ($urandom_range(0, 1) == 1));
            sdata_r = 2'($urandom);
            if (mph == 1) sdata_r[w_m] = (cnt < WIDTH) ? cw[cnt] : cp;
            ready_r = ($urandom_range(0, 9) < 6);
            req_e = req_r;
            rdy_e = ready_r;
            step();
            case (mph)
                0: begin
                    if (req_e != 2'b00) begin
                        w_m = (req_e == 2'b11) ? rr_m : req_e[1];
                        pend[w_m] = 1'b0;
                        cw  = wd[w_m];
                        cp  = pb[w_m];
                        cnt = 0;
                        mph = 1;
                    end
                end
                1: begin
                    cnt++;
                    if (cnt == LEN) mph = 2;
                end
                default: begin
                    if (rdy_e) begin
                        mph  = 0;
                        rr_m = ~w_m;
                    end
                end
            endcase
            chk("rnd gnt", gnt, (mph == 1) ? oh(w_m) : 2'b00);
            chk("rnd valid", out_valid, (mph == 2));
            chk("rnd busy", busy, (mph != 0));
            if (mph == 2) begin
                chk("rnd data", out_data, cw);
                chk("rnd src", out_src, w_m);
                chk("rnd perr", out_perr, eperr(cw, cp));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
Sequencer and arbiter that shares one 8-bit serial-in/parallel-out shift register between two serial requesters.
- Grants the shifter to one requester at a time, round-robin.
- Clocks exactly WIDTH bits from the granted source into the shifter, then presents the assembled word on a valid/ready output port tagged with the source ID.
- Sits between the serial front-ends and the parallel word consumer.

Parameters:
WIDTH, 8, data bits per transfer; must be >= 2
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
req  input  2  per-requester transfer request; held high until granted
sdata  input  2  per-requester serial data bit, LSB first
gnt  output  2  one-hot grant; requester i drives data bits on sdata[i] while gnt[i]=1
busy  output  1  high in every state except IDLE
out_valid  output  1  assembled word available
out_ready  input  1  consumer accepts word
out_data  output  WIDTH  assembled word
out_src  output  1  index of the requester that supplied out_data
out_perr  output  1  parity error flag (see Optional Feature)

Behaviour:
- Reset (clr_n=0, asynchronous, any state): state=IDLE, gnt=0, busy=0, out_valid=0, out_data=0, out_src=0, out_perr=0, bit counter=0, rr pointer=0 (requester 0 favoured).
- States: IDLE, SHIFT, [PARITY], HOLD. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req bit high: grant that requester regardless of the rr pointer.
  - Both req bits high: grant the requester indicated by the rr pointer.
  - On a grant: next state SHIFT, gnt[sel]=1, counter=0, shift register cleared to 0.
- SHIFT:
  - Each rising edge with gnt[i]=1: shreg <= {sdata[i], shreg[WIDTH-1:1]} (right shift, new bit enters the MSB), counter++.
  - The first bit sent ends up at the LSB after WIDTH shifts.
  - The edge that shifts in the WIDTH-th bit drops gnt and moves to HOLD (or to PARITY when the feature is enabled).
  - gnt is therefore high for exactly WIDTH cycles.
- HOLD:
  - out_valid=1, out_data=shreg, out_src=sel.
  - out_data and out_src are stable until the handshake.
  - On the edge where out_valid & out_ready: out_valid<=0, rr pointer <= ~sel, state IDLE.
  - One bubble cycle in IDLE before the next grant.
- Latency: req seen at edge 0 → gnt high over cycles 1..WIDTH → out_valid from cycle WIDTH+1. With out_ready already high, the next grant is issued at cycle WIDTH+3.
- Boundaries:
  - req deasserting mid-SHIFT is ignored; the transfer completes.
  - req changes during HOLD are ignored until IDLE.
  - A req from the non-granted source stays pending. The rr update guarantees it wins the next arbitration, so there is no starvation.
  - out_ready high outside HOLD has no effect.
  - Reset mid-SHIFT or mid-HOLD discards the partial or held word with no output.

Optional Feature:
Macro SHIFT_ARB_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, state PARITY holds gnt for one extra cycle and samples an even-parity bit from sdata[sel].
  - out_perr = (^shreg) ^ parity_bit, registered into HOLD and valid alongside out_valid.
  - gnt is then high for WIDTH+1 cycles and all latencies grow by 1.
- Undefined: the PARITY state and its logic are absent and out_perr is tied to 0.

Decomposition:
- Shared package shift_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2, ST_HOLD=2'd3
  - default WIDTH
- One sub-module: sipo_shift.
  - Ports: clk, clr_n, clr_sync, en, din, q[WIDTH-1:0].
  - Right shift with insert at MSB.
  - Instantiated once and driven by the controller FSM.

Test Plan:
- Reset: assert clr_n=0 mid-SHIFT at bit 3 → all outputs 0 immediately, IDLE after release, no out_valid.
- Single requester: req=2'b10, bits 1,0,1,0,0,1,0,1 → gnt=2'b10 for 8 cycles, out_data=8'hA5, out_src=1, out_valid at cycle 9.
- Contention: req=2'b11 from reset → requester 0 granted first. Second word comes from requester 1 (stays requesting), third from requester 0; words 8'h3C/8'hC3 tagged correctly.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid, out_data and out_src stable; gnt stays 0; both req ignored. out_ready=1 → IDLE next cycle.
- req dropped at bit 4 of 8 → transfer completes with 8 gnt cycles, word delivered.
- With SHIFT_ARB_PARITY_EN: send 8'hA5 with parity bit 0 → out_perr=0; with parity 1 → out_perr=1; gnt high for 9 cycles.
